odd_parity_frame_tx: RTL

//  Downstream consumer of the 4-bit odd parity generator. Accepts one nibble plus its
//  odd parity bit over a valid/ready handshake and serialises it as a UART-style frame:

---
 rtl/odd_parity_frame_tx_if.sv | 21 ++
 rtl/odd_parity_frame_tx.sv | 128 ++++++++++++
 2 files changed

// File: rtl/odd_parity_frame_tx_if.sv
// rtl/odd_parity_frame_tx_if.sv - nibble+parity valid/ready handshake into the frame transmitter
interface odd_parity_frame_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_par;

    modport master (
        output in_valid,
        output in_data,
        output in_par,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_par,
        output in_ready
    );
endinterface

// File: rtl/odd_parity_frame_tx.sv
// rtl/odd_parity_frame_tx.sv - serialises nibble+odd parity as start/d0..d3/parity/stop frame
module odd_parity_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    odd_parity_frame_tx_if.slave   bus,
    output logic                   tx,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   par_err
);
    localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
    localparam int BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam int STOP_W   = $clog2(STOP_LEN);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_LEN - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state, state_next;
    logic [BAUD_W-1:0] baud_cnt, baud_next;
    logic [STOP_W-1:0] stop_cnt, stop_next;
    logic [1:0]        bit_idx, bit_next;
    logic [3:0]        data_q;
    logic              par_q;
    logic              tx_next;
    logic              done_next;
    logic              accept;

    assign bus.in_ready = (state == IDLE);
    assign busy         = (state != IDLE);
    assign accept       = bus.in_valid & bus.in_ready;

    // tx_next is the line level for the state being entered, so tx itself is a pure flop
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        stop_next  = stop_cnt;
        bit_next   = bit_idx;
        tx_next    = tx;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (accept) begin
                    state_next = START;
                    baud_next  = '0;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    state_next = DATA;
                    baud_next  = '0;
                    bit_next   = 2'd0;
                    tx_next    = data_q[0];
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_next = '0;
                    if (bit_idx == 2'd3) begin
                        state_next = PARITY;
                        tx_next    = par_q;
                    end else begin
                        bit_next = bit_idx + 2'd1;
                        tx_next  = data_q[bit_idx + 2'd1];
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            PARITY: begin
                if (baud_cnt == BAUD_LAST) begin
                    state_next = STOP;
                    baud_next  = '0;
                    stop_next  = '0;
                    tx_next    = 1'b1;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (stop_cnt == STOP_LAST) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    stop_next = stop_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            stop_cnt   <= '0;
            bit_idx    <= 2'd0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
            data_q     <= 4'd0;
            par_q      <= 1'b0;
            par_err    <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_next;
            stop_cnt   <= stop_next;
            bit_idx    <= bit_next;
            tx         <= tx_next;
            frame_done <= done_next;
            if (accept) begin
                data_q  <= bus.in_data;
                par_q   <= bus.in_par;
                par_err <= (bus.in_par != ~^bus.in_data);
            end
        end
    end
endmodule
